// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx: WM8731 ADC I2S receiver, MSB-first stereo words plus 12-bit offset-binary display sample.
// Define I2S_RX_MONO_AVG_EN to derive wave_data from the left/right average instead of the left word.
module i2s_adc_rx #(
    parameter int DATA_W = 16,
    parameter int WAVE_W = 12
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              bclk,
    input  logic              lrck,
    input  logic              adcdat,
    output logic [DATA_W-1:0] left_sample,
    output logic [DATA_W-1:0] right_sample,
    output logic [WAVE_W-1:0] wave_data,
    output logic              sample_valid,
    output logic              frame_err
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {WAIT_SYNC, SKIP, SHIFT, HOLD} state_t;

    state_t            state_q;
    logic [2:0]        bclk_q;
    logic [1:0]        lrck_q, dat_q;
    logic              lrck_last_q, ch_q, left_good_q, valid_q, err_q;
    logic [CW-1:0]     cnt_q;
    logic [DATA_W-1:0] shreg_q, left_hold_q, left_q, right_q;
    logic [WAVE_W-1:0] wave_q;
    logic [DATA_W-1:0] shreg_d, src_d;
    logic [WAVE_W-1:0] wave_d;
    logic              rise, lr_edge, in_word;

    // bclk_q = {prev, sync2, sync1}; lrck/adcdat are delayed identically so they align with the edge
    assign rise    = bclk_q[1] & ~bclk_q[2];
    assign lr_edge = rise && (lrck_q[1] != lrck_last_q);
    assign in_word = (state_q == SKIP) || (state_q == SHIFT);
    assign shreg_d = {shreg_q[DATA_W-2:0], dat_q[1]};

`ifdef I2S_RX_MONO_AVG_EN
    logic [DATA_W:0] sum_d;
    assign sum_d = {left_hold_q[DATA_W-1], left_hold_q} + {shreg_d[DATA_W-1], shreg_d};
    assign src_d = sum_d[DATA_W:1];
`else
    assign src_d = left_hold_q;
`endif
    assign wave_d = {~src_d[DATA_W-1], src_d[DATA_W-2 -: WAVE_W-1]};

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_SYNC;
            bclk_q      <= '0;
            lrck_q      <= '0;
            dat_q       <= '0;
            lrck_last_q <= 1'b0;
            ch_q        <= 1'b0;
            left_good_q <= 1'b0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            shreg_q     <= '0;
            left_hold_q <= '0;
            left_q      <= '0;
            right_q     <= '0;
            wave_q      <= {1'b1, {(WAVE_W-1){1'b0}}};
        end else begin
            bclk_q  <= {bclk_q[1:0], bclk};
            lrck_q  <= {lrck_q[0], lrck};
            dat_q   <= {dat_q[0], adcdat};
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (rise) begin
                lrck_last_q <= lrck_q[1];
                if (lr_edge) begin
                    // a new left slot or a truncated word invalidates any pending left word
                    err_q   <= in_word;
                    ch_q    <= lrck_q[1];
                    state_q <= SKIP;
                    if (in_word || !lrck_q[1]) left_good_q <= 1'b0;
                end else begin
                    case (state_q)
                        SKIP: begin
                            cnt_q   <= '0;
                            state_q <= SHIFT;
                        end
                        SHIFT: begin
                            shreg_q <= shreg_d;
                            cnt_q   <= cnt_q + 1'b1;
                            if (cnt_q == LAST) begin
                                state_q <= HOLD;
                                if (!ch_q) begin
                                    left_hold_q <= shreg_d;
                                    left_good_q <= 1'b1;
                                end else if (left_good_q) begin
                                    left_q      <= left_hold_q;
                                    right_q     <= shreg_d;
                                    wave_q      <= wave_d;
                                    valid_q     <= 1'b1;
                                    left_good_q <= 1'b0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign left_sample  = left_q;
    assign right_sample = right_q;
    assign wave_data    = wave_q;
    assign sample_valid = valid_q;
    assign frame_err    = err_q;
endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb_i2s_adc_rx: directed and random I2S frames checked against a slot-level reference model.
module tb_i2s_adc_rx;
    localparam int W = 16;

    logic          clk_in = 0, reset = 0, bclk = 0, lrck = 0, adcdat = 0;
    logic [W-1:0]  left_sample, right_sample;
    logic [11:0]   wave_data;
    logic          sample_valid, frame_err;

    i2s_adc_rx #(.DATA_W(W), .WAVE_W(12)) dut (
        .clk_in(clk_in), .reset(reset), .bclk(bclk), .lrck(lrck), .adcdat(adcdat),
        .left_sample(left_sample), .right_sample(right_sample), .wave_data(wave_data),
        .sample_valid(sample_valid), .frame_err(frame_err)
    );

    always #5 clk_in = ~clk_in;

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // observed strobes
    logic [W-1:0] got_l[$], got_r[$];
    logic [11:0]  got_w[$];
    int           err_seen = 0, wide = 0;
    logic         sv_prev = 0;

    always @(negedge clk_in) begin
        if (sample_valid) begin
            got_l.push_back(left_sample);
            got_r.push_back(right_sample);
            got_w.push_back(wave_data);
        end
        if (sample_valid && sv_prev) wide++;
        if (frame_err) err_seen++;
        sv_prev = sample_valid;
    end

    // reference model: works on whole lrck slots, not bits
    logic [W-1:0] exp_l[$], exp_r[$];
    logic [11:0]  exp_w[$];
    int           m_prev_lr, m_prev_len, m_synced, m_left_good, exp_err;
    logic [W-1:0] m_left, m_out_l, m_out_r;
    logic [11:0]  m_out_w;

    function automatic logic [11:0] wave_of(input logic [W-1:0] l, input logic [W-1:0] r);
        int s;
`ifdef I2S_RX_MONO_AVG_EN
        s = (int'($signed(l)) + int'($signed(r))) >>> 1;
`else
        s = int'($signed(l)) + 0 * int'(r);
`endif
        return 12'((s + (1 << (W - 1))) >> (W - 12));
    endfunction

    task automatic model_reset();
        m_prev_lr = 0; m_prev_len = 0; m_synced = 0; m_left_good = 0; exp_err = 0;
        m_out_l = '0; m_out_r = '0; m_out_w = 12'd2048;
        exp_l.delete(); exp_r.delete(); exp_w.delete();
        got_l.delete(); got_r.delete(); got_w.delete();
        err_seen = 0;
    endtask

    task automatic model_slot(input int lr, input logic [W-1:0] word, input int len);
        if (lr != m_prev_lr) begin
            if (m_synced != 0 && m_prev_len < W + 2) begin
                exp_err++;
                m_left_good = 0;
            end
            if (lr == 0) m_left_good = 0;
            m_synced = 1;
            if (len >= W + 2) begin
                if (lr == 0) begin
                    m_left = word;
                    m_left_good = 1;
                end else if (m_left_good != 0) begin
                    m_out_l = m_left; m_out_r = word; m_out_w = wave_of(m_left, word);
                    exp_l.push_back(m_out_l); exp_r.push_back(m_out_r); exp_w.push_back(m_out_w);
                    m_left_good = 0;
                end
            end
            m_prev_len = len;
        end else begin
            m_prev_len += len;
        end
        m_prev_lr = lr;
    endtask

    task automatic send_bit(input int lr, input logic b, input int half);
        bclk = 0; lrck = lr[0]; adcdat = b;
        #(half);
        bclk = 1;
        #(half);
    endtask

    // slot bit 0 sees the lrck edge, bit 1 is the I2S delay bit, bits 2..W+1 carry the word
    task automatic send_slot(input int lr, input logic [W-1:0] word, input int len, input int ones, input int half);
        model_slot(lr, word, len);
        for (int i = 0; i < len; i++) begin
            logic b;
            if (i >= 2 && i < W + 2) b = word[W + 1 - i];
            else b = (ones != 0) ? 1'b1 : 1'($urandom_range(0, 1));
            send_bit(lr, b, half);
        end
    endtask

    task automatic checkpoint(input string tag);
        int n;
        #200;
        chk({tag, "_count"}, 64'(got_l.size()), 64'(exp_l.size()));
        n = (got_l.size() < exp_l.size()) ? got_l.size() : exp_l.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_left"}, 64'(got_l[i]), 64'(exp_l[i]));
            chk({tag, "_right"}, 64'(got_r[i]), 64'(exp_r[i]));
            chk({tag, "_wave"}, 64'(got_w[i]), 64'(exp_w[i]));
        end
        chk({tag, "_frame_err"}, 64'(err_seen), 64'(exp_err));
        chk({tag, "_left_out"}, 64'(left_sample), 64'(m_out_l));
        got_l.delete(); got_r.delete(); got_w.delete();
        exp_l.delete(); exp_r.delete(); exp_w.delete();
        err_seen = 0; exp_err = 0;
    endtask

    task automatic do_reset();
        bclk = 0; lrck = 0; adcdat = 0;
        #10 reset = 1;
        #30 reset = 0;
        #30;
        model_reset();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_left"}, 64'(left_sample), 64'(0));
        chk({tag, "_right"}, 64'(right_sample), 64'(0));
        chk({tag, "_wave"}, 64'(wave_data), 64'(12'd2048));
        chk({tag, "_valid"}, 64'(sample_valid), 64'(0));
        chk({tag, "_err"}, 64'(frame_err), 64'(0));
    endtask

    initial begin
        #2;
        do_reset();
        chk_reset_outputs("rst");

        // right slot first after reset is ignored, then a full pair
        send_slot(1, 16'(($urandom)), 32, 0, 40);
        send_slot(0, 16'h7FFF, 32, 0, 40);
        send_slot(1, 16'h8000, 32, 0, 40);
        checkpoint("pair");
        chk("pair_l", 64'(left_sample), 64'(16'h7FFF));
        chk("pair_r", 64'(right_sample), 64'(16'h8000));
`ifdef I2S_RX_MONO_AVG_EN
        chk("pair_w", 64'(wave_data), 64'(12'h7FF));
`else
        chk("pair_w", 64'(wave_data), 64'(12'hFFF));
`endif

        // 48 frames with extra slot bits driven high
        for (int f = 0; f < 48; f++) begin
            send_slot(0, 16'h1234, 32, 1, 40);
            send_slot(1, 16'h1234, 32, 1, 40);
        end
        checkpoint("x48");
        chk("x48_w", 64'(wave_data), 64'(12'h923));

        // left word truncated after 10 data bits
        send_slot(0, 16'(($urandom)), 32, 0, 40);
        send_slot(1, 16'(($urandom)), 32, 0, 40);
        send_slot(0, 16'(($urandom)), 12, 0, 40);
        send_slot(1, 16'(($urandom)), 32, 0, 40);
        send_slot(0, 16'(($urandom)), 32, 0, 40);
        send_slot(1, 16'(($urandom)), 32, 0, 40);
        checkpoint("trunc");

        // clk_in exactly 4x bclk
        send_slot(0, 16'hA5A5, 32, 0, 20);
        send_slot(1, 16'h5A5A, 32, 0, 20);
        send_slot(0, 16'hA5A5, 24, 0, 20);
        send_slot(1, 16'h5A5A, 18, 0, 20);
        checkpoint("fast");
        chk("fast_l", 64'(left_sample), 64'(16'hA5A5));
        chk("fast_r", 64'(right_sample), 64'(16'h5A5A));

        // random words and slot lengths, including short slots
        for (int s = 0; s < 80; s++) begin
            int r, len;
            r = $urandom_range(0, 9);
            len = (r == 0) ? 1 : (r == 1) ? $urandom_range(2, W + 1) : $urandom_range(W + 2, 32);
            send_slot(s % 2, 16'(($urandom)), len, 0, 40);
        end
        checkpoint("rand");

        // reset in the middle of a left word
        send_slot(0, 16'(($urandom)), 10, 0, 40);
        do_reset();
        chk_reset_outputs("midrst");
        send_slot(1, 16'(($urandom)), 32, 0, 40);
        send_slot(0, 16'(($urandom)), 32, 0, 40);
        send_slot(1, 16'(($urandom)), 32, 0, 40);
        checkpoint("resync");

        chk("strobe_width", 64'(wide), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
